// File: rtl/reg_file_pkg.sv
// Shared register-file constants and address/data types for decode and writeback.
package reg_file_pkg;

   localparam int unsigned AD_SIZE  = 5;
   localparam int unsigned REG_SIZE = 32;
   localparam int unsigned DA_SIZE  = 32;

   typedef logic [AD_SIZE-1:0] reg_addr_t;
   typedef logic [DA_SIZE-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port, two combinational read ports.
interface reg_file_if
   import reg_file_pkg::*;
#(
   parameter int unsigned ADSize = AD_SIZE,
   parameter int unsigned DASize = DA_SIZE
);

   logic              RegWrite;
   logic [ADSize-1:0] Write_ADDR;
   logic [DASize-1:0] DIN;
   logic [ADSize-1:0] Read_ADDR_1;
   logic [ADSize-1:0] Read_ADDR_2;
   logic [DASize-1:0] OUT_1;
   logic [DASize-1:0] OUT_2;

   // Writeback/decode side drives addresses and data, receives operands.
   modport master (
      output RegWrite,
      output Write_ADDR,
      output DIN,
      output Read_ADDR_1,
      output Read_ADDR_2,
      input  OUT_1,
      input  OUT_2
   );

   // Register file side.
   modport slave (
      input  RegWrite,
      input  Write_ADDR,
      input  DIN,
      input  Read_ADDR_1,
      input  Read_ADDR_2,
      output OUT_1,
      output OUT_2
   );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// General-purpose register file: two zero-latency read ports, one synchronous
// write port, asynchronous active-low clear of every entry.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned ADSize  = AD_SIZE,
   parameter int unsigned REGSize = REG_SIZE,
   parameter int unsigned DASize  = DA_SIZE
) (
   input logic         clk,
   input logic         rst,
   reg_file_if.slave   bus
);

   // Addresses at or above this limit do not map to a register.
   localparam logic [ADSize:0] REG_LIMIT = (ADSize+1)'(REGSize);

   logic [DASize-1:0] mem [0:REGSize-1];

   logic wr_ok_c;
   logic rd1_ok_c;
   logic rd2_ok_c;

   // Range qualification for each port.
   always_comb begin
      wr_ok_c  = ({1'b0, bus.Write_ADDR}  < REG_LIMIT);
      rd1_ok_c = ({1'b0, bus.Read_ADDR_1} < REG_LIMIT);
      rd2_ok_c = ({1'b0, bus.Read_ADDR_2} < REG_LIMIT);
   end

   // Storage: async clear, single write per rising edge, no hardwired zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(REGSize); i++) begin
            mem[i] <= '0;
         end
      end else if (bus.RegWrite && wr_ok_c) begin
         mem[bus.Write_ADDR] <= bus.DIN;
      end
   end

   // Combinational reads with no write bypass; zero in reset or out of range.
   always_comb begin
      bus.OUT_1 = '0;
      bus.OUT_2 = '0;
      if (rst && rd1_ok_c) begin
         bus.OUT_1 = mem[bus.Read_ADDR_1];
      end
      if (rst && rd2_ok_c) begin
         bus.OUT_2 = mem[bus.Read_ADDR_2];
      end
   end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed plus random checking of reg_file against an array reference model.
`timescale 1ns/1ps
module tb_reg_file;
   import reg_file_pkg::*;

   localparam int unsigned NREG = REG_SIZE;

   logic clk;
   logic rst;

   reg_file_if #(.ADSize(AD_SIZE), .DASize(DA_SIZE)) bus ();

   reg_file #(.ADSize(AD_SIZE), .REGSize(REG_SIZE), .DASize(DA_SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] model [0:NREG-1];
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (!rst || int'(a) >= int'(NREG)) return 32'h0;
      return model[a];
   endfunction

   task automatic check_reads(input string tag);
      check({tag, "/OUT_1"}, bus.OUT_1, exp_read(bus.Read_ADDR_1));
      check({tag, "/OUT_2"}, bus.OUT_2, exp_read(bus.Read_ADDR_2));
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < int'(NREG); i++) begin
         check($sformatf("%s/mem[%0d]", tag, i), dut.mem[i], model[i]);
      end
   endtask

   task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
      bus.Read_ADDR_1 = a1;
      bus.Read_ADDR_2 = a2;
      #1;
   endtask

   // Advance one rising edge, applying the write rule to the model.
   task automatic tick();
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      we = bus.RegWrite;
      wa = bus.Write_ADDR;
      wd = bus.DIN;
      @(posedge clk);
      if (rst && we && int'(wa) < int'(NREG)) model[wa] = wd;
      #1;
   endtask

   task automatic drive_write(input logic we, input logic [4:0] a, input logic [31:0] d);
      bus.RegWrite   = we;
      bus.Write_ADDR = a;
      bus.DIN        = d;
   endtask

   initial begin
      for (int i = 0; i < int'(NREG); i++) model[i] = 32'h0;
      rst = 1'b0;
      drive_write(1'b0, 5'd0, 32'h0);
      bus.Read_ADDR_1 = 5'd0;
      bus.Read_ADDR_2 = 5'd0;

      // Reset held for one period.
      #3;
      check("rst_hold/OUT_1", bus.OUT_1, 32'h0);
      check("rst_hold/OUT_2", bus.OUT_2, 32'h0);
      tick();
      check_mem("rst_hold");
      rst = 1'b1;
      #1;
      check("rst_rel/OUT_1", bus.OUT_1, 32'h0);
      check("rst_rel/OUT_2", bus.OUT_2, 32'h0);

      // Sequential writes with reads of regs 1 and 2: no bypass.
      set_reads(5'd1, 5'd2);
      for (int k = 0; k < 4; k++) begin
         drive_write(1'b1, 5'(k), 32'(k + 1));
         #1;
         check_reads($sformatf("seq%0d_pre", k));
         tick();
         check_reads($sformatf("seq%0d_post", k));
      end
      drive_write(1'b1, 5'd1, 32'd99);
      drive_write(1'b0, 5'd0, 32'h0);
      check("seq/OUT_1_final", bus.OUT_1, 32'd2);
      check("seq/OUT_2_final", bus.OUT_2, 32'd3);

      // Read-only phase; write inputs toggled but disabled.
      begin
         logic [4:0]  ra1 [4];
         logic [4:0]  ra2 [4];
         logic [31:0] e1  [4];
         logic [31:0] e2  [4];
         ra1 = '{5'd1, 5'd3, 5'd2, 5'd4};
         ra2 = '{5'd4, 5'd2, 5'd3, 5'd1};
         e1  = '{32'd2, 32'd4, 32'd3, 32'd0};
         e2  = '{32'd0, 32'd3, 32'd4, 32'd2};
         for (int k = 0; k < 4; k++) begin
            drive_write(1'b0, 5'(k), 32'hF);
            set_reads(ra1[k], ra2[k]);
            check($sformatf("ro%0d/OUT_1", k), bus.OUT_1, e1[k]);
            check($sformatf("ro%0d/OUT_2", k), bus.OUT_2, e2[k]);
            tick();
         end
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ro_keep/mem[%0d]", i), dut.mem[i], 32'(i + 1));
      end

      // Both ports on the same register.
      set_reads(5'd3, 5'd3);
      check("same/OUT_1", bus.OUT_1, 32'd4);
      check("same/OUT_2", bus.OUT_2, 32'd4);

      // Register 0 is ordinary storage.
      drive_write(1'b1, 5'd0, 32'hDEADBEEF);
      set_reads(5'd0, 5'd5);
      check("r0_pre/OUT_1", bus.OUT_1, 32'd1);
      tick();
      drive_write(1'b0, 5'd0, 32'h0);
      check("r0_post/OUT_1", bus.OUT_1, 32'hDEADBEEF);
      check("r0_post/OUT_2", bus.OUT_2, 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         drive_write(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
         set_reads(5'($urandom), 5'($urandom));
         check_reads($sformatf("rnd%0d_pre", n));
         tick();
         check_reads($sformatf("rnd%0d_post", n));
      end
      check_mem("rnd_end");

      // Asynchronous reset between edges, with a write edge while held.
      for (int i = 0; i < 8; i++) begin
         drive_write(1'b1, 5'(i + 8), 32'hA5A50000 + 32'(i));
         tick();
      end
      drive_write(1'b0, 5'd0, 32'h0);
      set_reads(5'd8, 5'd15);
      check("mid_pre/OUT_1", bus.OUT_1, 32'hA5A50000);
      check("mid_pre/OUT_2", bus.OUT_2, 32'hA5A50007);
      #2;
      rst = 1'b0;
      for (int i = 0; i < int'(NREG); i++) model[i] = 32'h0;
      #0.5;
      check("mid_rst/OUT_1", bus.OUT_1, 32'h0);
      check("mid_rst/OUT_2", bus.OUT_2, 32'h0);
      drive_write(1'b1, 5'd8, 32'h12345678);
      tick();
      check("mid_rst_wr/OUT_1", bus.OUT_1, 32'h0);
      check_mem("mid_rst_wr");
      rst = 1'b1;
      drive_write(1'b0, 5'd0, 32'h0);
      #1;
      check_reads("mid_rel");
      drive_write(1'b1, 5'd8, 32'h0BADF00D);
      tick();
      drive_write(1'b0, 5'd0, 32'h0);
      check("mid_rel_wr/OUT_1", bus.OUT_1, 32'h0BADF00D);
      check_mem("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- Multi-port general-purpose register file for the datapath.
- Two combinational read ports and one synchronous write port.
- Sits between decode (register addresses), the ALU operand path (OUT_1/OUT_2) and writeback (DIN/Write_ADDR/RegWrite).
- Storage array is named mem, so benches can reference mem[i] hierarchically.

Parameters:
- ADSize, 5, width of every register address port.
- REGSize, 32, number of registers (entries in mem); must satisfy REGSize <= 2**ADSize.
- DASize, 32, data width of each register and of DIN/OUT_1/OUT_2.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst  input  1  reset; one clock, asynchronous and active-low (asserted when 0).
- RegWrite  input  1  write enable, sampled at rising clk.
- Write_ADDR  input  ADSize  write register index.
- DIN  input  DASize  write data.
- Read_ADDR_1  input  ADSize  read port 1 register index.
- Read_ADDR_2  input  ADSize  read port 2 register index.
- OUT_1  output  DASize  contents of mem[Read_ADDR_1].
- OUT_2  output  DASize  contents of mem[Read_ADDR_2].

Behaviour:
- Storage: mem[0..REGSize-1], each DASize bits. All entries, including index 0, are ordinary writable registers with no hardwired zero.
- Reset:
  - rst=0 immediately clears every mem entry to 0, with no clock needed.
  - While rst=0, writes are blocked, and OUT_1/OUT_2 read 0 for any address.
  - Reset asserted mid-operation overrides any write in progress.
- Write:
  - On posedge clk with rst=1 and RegWrite=1, mem[Write_ADDR] <= DIN.
  - With RegWrite=0, no entry changes; DIN and Write_ADDR are don't-care.
- Read:
  - Purely combinational, zero latency: OUT_n = mem[Read_ADDR_n].
  - Output changes in the same delta as an address change, or after the clock edge that updates the addressed entry.
- Read-during-write, same address:
  - No bypass. Before the edge, OUT returns the old value.
  - After the edge, OUT returns DIN.
- Both read ports may address the same register simultaneously; both return the same value.
- Out of range (Write_ADDR or Read_ADDR >= REGSize, only possible when REGSize < 2**ADSize):
  - A write to such an address is ignored.
  - A read of such an address returns 0.
- No other state and no handshake. Exactly one write per cycle.

Decomposition:
- Shared package holds the default constants (ADSize=5, REGSize=32, DASize=32) plus address and data typedefs sized from them, for reuse by decode/writeback.
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset: hold rst=0 for one period, then release. All mem[i]=0; with Read_ADDR_1=0 and Read_ADDR_2=0, OUT_1=0 and OUT_2=0.
- Sequential writes: RegWrite=1 on consecutive cycles with (Write_ADDR,DIN) = (0,1), (1,2), (2,3), (3,4), while Read_ADDR_1=1 and Read_ADDR_2=2.
  - OUT_1 becomes 2 only after the edge writing reg1.
  - OUT_2 becomes 3 only after the edge writing reg2, showing no bypass.
- Read-only phase: RegWrite=0, DIN=0xF, Write_ADDR cycling 0..3.
  - Reads (1,4) -> (2,0); (3,2) -> (4,3); (2,3) -> (3,4); (4,1) -> (0,2).
  - mem[0..3] remains 1,2,3,4, i.e. no write leaks.
- Same-address read on both ports: Read_ADDR_1=Read_ADDR_2=3 -> OUT_1=OUT_2=4.
- Async reset mid-run: drive rst=0 between clock edges after registers are loaded. OUT_1 and OUT_2 drop to 0 immediately, and a RegWrite=1 edge during reset writes nothing.
- Register 0: write 0xDEADBEEF to address 0 -> reading address 0 returns 0xDEADBEEF.
